imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle, asynchronous-read instruction memory (word-addressed, 2^MEMWIDTH bytes).
- Owns the PC register and drives the memory address.
- Captures each returned word into a 2-entry buffer and presents {pc, instr} to decode with a valid/ready handshake.
- Handles stall (halt), redirect (branch/jump/trap) with flush, and out-of-range/misaligned fetch faults.

Parameters:
MEMWIDTH, 14, byte-address width of the instruction memory; legal PCs are below 2^MEMWIDTH.
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned and in range.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
imem_addr_o  output  32  fetch address to instruction memory (= pc_q, registered source)
imem_rdata_i  input  32  instruction word returned combinationally for imem_addr_o
halt_i  input  1  level; when 1 no new fetches are accepted (buffer still drains)
redirect_i  input  1  one-cycle pulse; load redirect_pc_i and flush buffer
redirect_pc_i  input  32  redirect target
valid_o  output  1  buffer head holds a valid instruction
ready_i  input  1  decode accepts head this cycle when valid_o=1
instr_o  output  32  head instruction
pc_o  output  32  PC of head instruction
fault_o  output  1  sticky fetch fault flag
fault_pc_o  output  32  PC that caused the fault

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Ports are clk_i and rst_i.
- Reset:
  - pc_q=RESET_PC, buffer count=0, state=RUN.
  - valid_o=0, instr_o=0, pc_o=0, fault_o=0, fault_pc_o=0.
  - Reset asserted mid-operation discards buffer contents and any pending fault in the same edge.
- States:
  - RUN: normal fetching.
  - FAULT: no fetches, pc_q frozen.
- Handshake:
  - pop = valid_o & ready_i.
  - push = state==RUN & !halt_i & !redirect_i & pc_ok & (count<2 | pop).
  - pc_ok = (pc_q[1:0]==0) & (pc_q[31:MEMWIDTH]==0).
- On push: enqueue {pc_q, imem_rdata_i}; pc_q <= pc_q+4. The adder wraps mod 2^32, but wrap is caught by the range check first.
- Buffer: 2-entry FIFO; head drives instr_o/pc_o; valid_o = (count!=0).
  - Simultaneous push and pop at count=2 is allowed, so sustained throughput is 1 instr/cycle.
  - instr_o/pc_o are held stable while valid_o=1 and ready_i=0.
  - instr_o/pc_o hold their last value when empty; verify must not check them while valid_o=0.
- Redirect (highest priority after reset):
  - Next edge: count=0, pc_q=redirect_pc_i, no push or pop that edge, state=RUN, fault_o cleared.
  - fault_pc_o retains its last value.
  - Penalty: valid_o low the cycle after the redirect edge; the target instruction is valid one edge later.
- Fault:
  - In RUN, when !pc_ok & !halt_i & !redirect_i: state=FAULT, fault_o=1, fault_pc_o=pc_q. Entries already buffered still drain normally.
  - Exit FAULT only via redirect or reset.
  - halt_i=1 suppresses fault detection, so a stalled bad PC does not fault until released.
- Latency:
  - First valid_o=1 after the first rising edge with rst_i=0.
  - Memory read is combinational, so fetch-to-valid is one edge.
- Width rules: all PC arithmetic is 32-bit unsigned; range check compares bits [31:MEMWIDTH] to zero.

Test Plan:
- Reset release, ready_i=1, memory holds 0x11111111, 0x22222222, ... at words 0..: valid_o rises after first edge; pc_o/instr_o = 0/0x11111111, 4/0x22222222, 8/0x33333333 on consecutive cycles (no bubbles).
- ready_i=0 for 5 cycles after reset: count saturates at 2; pc_q stops at 8; instr_o holds 0x11111111 stable. Then ready_i=1: sequence resumes 0, 4, 8 with no loss or duplicate.
- Redirect to 0x40 while buffer holds PCs 4 and 8: next cycle valid_o=0; following cycle pc_o=0x40 with word 16's data. PCs 4 and 8 are never presented after the redirect.
- Sequential fetch to PC=0x3FFC (MEMWIDTH=14): word at 0x3FFC is delivered. Next cycle fault_o=1, fault_pc_o=0x4000, no further pushes. Redirect to 0x0 clears fault_o and fetching restarts at 0.
- Redirect to 0x102 (misaligned): fault_o=1, fault_pc_o=0x102 one edge after the first RUN cycle. halt_i=1 held over a bad PC gives no fault until halt_i drops.
- rst_i asserted while count=2 and fault_o=1: next edge valid_o=0, fault_o=0, imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from an async-read instruction
// memory into a 2-entry buffer and hands {pc, instr} to decode with valid/ready.
module imem_fetch_ctrl #(
    parameter int          MEMWIDTH = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [1:0]  count_q;
    logic [31:0] ent_pc_q    [2];
    logic [31:0] ent_instr_q [2];
    logic [31:0] fault_pc_q;

    logic pc_ok, pop, push, fault_det;

    assign pc_ok     = (pc_q[1:0] == 2'b00) && (pc_q[31:MEMWIDTH] == '0);
    assign pop       = valid_o && ready_i;
    assign push      = (state_q == ST_RUN) && !halt_i && !redirect_i && pc_ok &&
                       ((count_q < 2'd2) || pop);
    assign fault_det = (state_q == ST_RUN) && !halt_i && !redirect_i && !pc_ok;

    assign imem_addr_o = pc_q;
    assign valid_o     = (count_q != 2'd0);
    assign instr_o     = ent_instr_q[0];
    assign pc_o        = ent_pc_q[0];
    assign fault_o     = (state_q == ST_FAULT);
    assign fault_pc_o  = fault_pc_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = ST_RUN;
        end else if (fault_det) begin
            state_d = ST_FAULT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer is a shift register: entry 0 is always the head presented to decode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            fault_pc_q <= 32'h0;
            // NOTE: the buffer storage is reset too, because instr_o/pc_o must read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                ent_pc_q[i]    <= 32'h0;
                ent_instr_q[i] <= 32'h0;
            end
        end else if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            count_q <= 2'd0;
        end else begin
            if (fault_det) begin
                fault_pc_q <= pc_q;
            end
            if (push) begin
                pc_q <= pc_q + 32'd4;
            end
            case ({push, pop})
                2'b10: begin
                    count_q                 <= count_q + 2'd1;
                    ent_pc_q[count_q[0]]    <= pc_q;
                    ent_instr_q[count_q[0]] <= imem_rdata_i;
                end
                2'b01: begin
                    count_q        <= count_q - 2'd1;
                    ent_pc_q[0]    <= ent_pc_q[1];
                    ent_instr_q[0] <= ent_instr_q[1];
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent_pc_q[0]    <= pc_q;
                        ent_instr_q[0] <= imem_rdata_i;
                    end else begin
                        ent_pc_q[0]    <= ent_pc_q[1];
                        ent_instr_q[0] <= ent_instr_q[1];
                        ent_pc_q[1]    <= pc_q;
                        ent_instr_q[1] <= imem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
